reg_file_arbitrated: RTL and testbench

// - Multi-master register file: per-register arbitration, valid/ack write handshake, byte strobes, write protection.
// - Successor to the fixed-priority direct-access file: selectable round-robin arbitration, error responses, per-register reset values.
// - Sits between control masters (CPU bridge, debug port, HW engines) and the config/status fabric; all registers visible in parallel.

---
 rtl/reg_file_arbitrated.sv | 145 ++++++++++++++
 tb/tb_reg_file_arbitrated.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_arbitrated.sv
// ============================================================================
// Module   : reg_file_arbitrated
// Purpose  : Multi-master register file with per-register arbitration,
//            byte strobes, write protection and error responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_arbitrated #(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_REGISTERS  = 16,
    parameter int NUM_MASTERS    = 2,
    parameter int ARB_MODE       = 1,
    parameter logic [NUM_REGISTERS-1:0]                     RO_MASK      = '0,
    parameter logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_MASTERS-1:0]                        wr_req,
    input  logic [NUM_MASTERS*$clog2(NUM_REGISTERS)-1:0]  wr_addr,
    input  logic [NUM_MASTERS*REGISTER_WIDTH-1:0]         wr_data,
    input  logic [NUM_MASTERS*REGISTER_WIDTH/8-1:0]       wr_strb,
    output logic [NUM_MASTERS-1:0]                        wr_ack,
    output logic [NUM_MASTERS-1:0]                        wr_err,
    output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]       rd_data,
    output logic [NUM_REGISTERS-1:0]                      reg_updated
);

    localparam int ADDR_WIDTH = $clog2(NUM_REGISTERS);
    localparam int STRB_WIDTH = REGISTER_WIDTH / 8;
    localparam int MIDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam bit USE_RR     = (ARB_MODE == 1) && (NUM_MASTERS > 1);

    logic [ADDR_WIDTH-1:0]     w_addr     [NUM_MASTERS];
    logic [REGISTER_WIDTH-1:0] w_data     [NUM_MASTERS];
    logic [STRB_WIDTH-1:0]     w_strb     [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]    w_err;
    logic [NUM_MASTERS-1:0]    w_granted;
    logic [NUM_REGISTERS-1:0]  w_win_valid;
    logic [MIDX_WIDTH-1:0]     w_win_idx  [NUM_REGISTERS];
    logic [REGISTER_WIDTH-1:0] w_win_data [NUM_REGISTERS];
    logic [STRB_WIDTH-1:0]     w_win_strb [NUM_REGISTERS];
    logic [MIDX_WIDTH-1:0]     w_last     [NUM_REGISTERS];

    logic [NUM_REGISTERS-1:0][REGISTER_WIDTH-1:0] r_regs;
    logic [NUM_REGISTERS-1:0]                     r_upd;

    // Errored requests bypass arbitration entirely and are acked at once.
    always_comb begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_addr[m] = wr_addr[m*ADDR_WIDTH +: ADDR_WIDTH];
            w_data[m] = wr_data[m*REGISTER_WIDTH +: REGISTER_WIDTH];
            w_strb[m] = wr_strb[m*STRB_WIDTH +: STRB_WIDTH];
            w_err[m]  = 1'b0;
            if (wr_req[m]) begin
                if (int'(w_addr[m]) >= NUM_REGISTERS) begin
                    w_err[m] = 1'b1;
                end else if (RO_MASK[w_addr[m]]) begin
                    w_err[m] = 1'b1;
                end
            end
        end
    end

    // Per-register search starting just after the last winner (or at 0).
    always_comb begin
        int v_start;
        int v_cand;
        v_start   = 0;
        v_cand    = 0;
        w_granted = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            w_win_valid[i] = 1'b0;
            w_win_idx[i]   = '0;
            w_win_data[i]  = '0;
            w_win_strb[i]  = '0;
            v_start        = USE_RR ? int'(w_last[i]) + 1 : 0;
            for (int k = 0; k < NUM_MASTERS; k++) begin
                v_cand = (v_start + k) % NUM_MASTERS;
                if (!w_win_valid[i] && wr_req[v_cand] && !w_err[v_cand] &&
                    (int'(w_addr[v_cand]) == i)) begin
                    w_win_valid[i]    = 1'b1;
                    w_win_idx[i]      = MIDX_WIDTH'(v_cand);
                    w_win_data[i]     = w_data[v_cand];
                    w_win_strb[i]     = w_strb[v_cand];
                    w_granted[v_cand] = 1'b1;
                end
            end
        end
    end

    generate
        if (USE_RR) begin : g_rr
            logic [MIDX_WIDTH-1:0] r_last [NUM_REGISTERS];

            always_ff @(posedge clk) begin
                for (int i = 0; i < NUM_REGISTERS; i++) begin
                    if (rst) begin
                        r_last[i] <= MIDX_WIDTH'(NUM_MASTERS - 1);
                    end else if (w_win_valid[i]) begin
                        r_last[i] <= w_win_idx[i];
                    end
                end
            end

            always_comb begin
                for (int i = 0; i < NUM_REGISTERS; i++) begin
                    w_last[i] = r_last[i];
                end
            end
        end else begin : g_fixed
            always_comb begin
                for (int i = 0; i < NUM_REGISTERS; i++) begin
                    w_last[i] = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= RESET_VALUES;
            r_upd  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_upd[i] <= w_win_valid[i];
                if (w_win_valid[i]) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_win_strb[i][b]) begin
                            r_regs[i][b*8 +: 8] <= w_win_data[i][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign wr_ack      = rst ? '0 : (w_err | w_granted);
    assign wr_err      = rst ? '0 : w_err;
    assign rd_data     = r_regs;
    assign reg_updated = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_arbitrated.sv
// ============================================================================
// Module   : tb_reg_file_arbitrated
// Purpose  : Scoreboard bench for reg_file_arbitrated (round-robin and
//            fixed-priority instances) against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_arbitrated;

    localparam int NR = 16;
    localparam int NM = 3;
    localparam logic [NR-1:0] ROM = 16'h8000;
    localparam logic [NR-1:0][31:0] RV = {384'h0, 32'hCAFE_0000, 96'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Round-robin instance
    logic          rst = 1'b1;
    logic [2:0]    wr_req = '0;
    logic [11:0]   wr_addr = '0;
    logic [95:0]   wr_data = '0;
    logic [11:0]   wr_strb = '0;
    logic [2:0]    wr_ack, wr_err;
    logic [511:0]  rd_data;
    logic [15:0]   reg_updated;

    reg_file_arbitrated #(
        .REGISTER_WIDTH(32), .NUM_REGISTERS(NR), .NUM_MASTERS(NM),
        .ARB_MODE(1), .RO_MASK(ROM), .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_ack(wr_ack),
        .wr_err(wr_err), .rd_data(rd_data), .reg_updated(reg_updated)
    );

    // Fixed-priority instance
    logic          f_rst = 1'b1;
    logic [2:0]    f_req = '0;
    logic [11:0]   f_addr = '0;
    logic [95:0]   f_data = '0;
    logic [11:0]   f_strb = '0;
    logic [2:0]    f_ack, f_err;
    logic [511:0]  f_rd;
    logic [15:0]   f_upd;
    bit            f_done = 1'b0;

    reg_file_arbitrated #(
        .REGISTER_WIDTH(32), .NUM_REGISTERS(NR), .NUM_MASTERS(NM),
        .ARB_MODE(0), .RO_MASK(ROM), .RESET_VALUES(RV)
    ) dut_fp (
        .clk(clk), .rst(f_rst), .wr_req(f_req), .wr_addr(f_addr),
        .wr_data(f_data), .wr_strb(f_strb), .wr_ack(f_ack),
        .wr_err(f_err), .rd_data(f_rd), .reg_updated(f_upd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]           ack;
        logic [2:0]           err;
        logic [15:0]          upd;
        logic [NR-1:0][31:0]  rd;
    } exp_t;

    exp_t sb[$];

    // Reference model state: what the DUT should show in the current cycle
    logic [NR-1:0][31:0] mr;
    int                  ml [NR];
    logic [15:0]         mu;

    // Master-side stimulus
    bit         m_rst = 1'b1;
    logic [2:0] m_req = '0;
    logic [3:0] m_addr [NM];
    logic [31:0] m_data [NM];
    logic [3:0] m_strb [NM];

    function automatic logic [31:0] rdreg(input logic [511:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    // Drive one cycle, predict the response, advance the model across the edge.
    task automatic step();
        logic [2:0]  ea, ee;
        logic [15:0] nu;
        int          win [NR];
        int          c;
        rst    = m_rst;
        wr_req = m_req;
        for (int m = 0; m < NM; m++) begin
            wr_addr[m*4 +: 4]   = m_addr[m];
            wr_data[m*32 +: 32] = m_data[m];
            wr_strb[m*4 +: 4]   = m_strb[m];
        end
        ea = '0; ee = '0; nu = '0;
        for (int i = 0; i < NR; i++) win[i] = -1;
        if (!m_rst) begin
            for (int m = 0; m < NM; m++)
                if (m_req[m] && ROM[m_addr[m]]) begin
                    ea[m] = 1'b1;
                    ee[m] = 1'b1;
                end
            for (int i = 0; i < NR; i++) begin
                for (int k = 1; k <= NM; k++) begin
                    c = (ml[i] + k) % NM;
                    if (win[i] < 0 && m_req[c] && !ee[c] && int'(m_addr[c]) == i) win[i] = c;
                end
                if (win[i] >= 0) begin
                    ea[win[i]] = 1'b1;
                    nu[i]      = 1'b1;
                end
            end
        end
        sb.push_back('{ack: ea, err: ee, upd: mu, rd: mr});
        if (m_rst) begin
            mr = RV;
            mu = '0;
            for (int i = 0; i < NR; i++) ml[i] = NM - 1;
        end else begin
            mu = nu;
            for (int i = 0; i < NR; i++)
                if (win[i] >= 0) begin
                    for (int b = 0; b < 4; b++)
                        if (m_strb[win[i]][b]) mr[i][b*8 +: 8] = m_data[win[i]][b*8 +: 8];
                    ml[i] = win[i];
                end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) if (ea[m]) m_req[m] = 1'b0;
    endtask

    task automatic req(input int m, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        m_req[m]  = 1'b1;
        m_addr[m] = a;
        m_data[m] = d;
        m_strb[m] = s;
    endtask

    // Monitor: compares the DUT against the queued prediction each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ack", {29'b0, wr_ack}, {29'b0, e.ack});
                chk("err", {29'b0, wr_err}, {29'b0, e.err});
                chk("upd", {16'b0, reg_updated}, {16'b0, e.upd});
                for (int i = 0; i < NR; i++)
                    chk($sformatf("rd%0d", i), rdreg(rd_data, i), e.rd[i]);
            end
        end
    end

    // Fixed-priority starvation scenario on the second instance
    initial begin
        repeat (2) @(posedge clk);
        #1;
        f_rst = 1'b0;
        f_req = 3'b111;
        f_addr = {4'd5, 4'd5, 4'd5};
        f_data = {32'd3, 32'd2, 32'd1};
        f_strb = 12'hFFF;
        for (int n = 0; n < 4; n++) begin
            #1;
            chk("fp_ack_m0", {29'b0, f_ack}, 32'b001);
            chk("fp_err", {29'b0, f_err}, 32'b000);
            @(posedge clk);
            #1;
            chk("fp_reg5_m0", rdreg(f_rd, 5), 32'd1);
        end
        f_req = 3'b110;
        #1;
        chk("fp_ack_m1", {29'b0, f_ack}, 32'b010);
        @(posedge clk);
        #1;
        chk("fp_reg5_m1", rdreg(f_rd, 5), 32'd2);
        f_req = 3'b100;
        #1;
        chk("fp_ack_m2", {29'b0, f_ack}, 32'b100);
        @(posedge clk);
        #1;
        chk("fp_reg5_m2", rdreg(f_rd, 5), 32'd3);
        f_req  = 3'b000;
        f_done = 1'b1;
    end

    initial begin
        int r;
        for (int m = 0; m < NM; m++) begin
            m_addr[m] = '0; m_data[m] = '0; m_strb[m] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        mr = RV;
        mu = '0;
        for (int i = 0; i < NR; i++) ml[i] = NM - 1;
        chk("rst_reg3", rdreg(rd_data, 3), 32'hCAFE_0000);
        chk("rst_reg0", rdreg(rd_data, 0), 32'h0);

        // Request held through reset is acked in the first free cycle
        req(1, 4'd4, 32'h0000_0044, 4'hF);
        step(); step();
        m_rst = 1'b0;
        step();
        chk("post_rst_reg4", rdreg(rd_data, 4), 32'h0000_0044);

        // Full-word write then strobed overwrite
        req(0, 4'd2, 32'h1234_5678, 4'hF);
        step();
        chk("reg2_full", rdreg(rd_data, 2), 32'h1234_5678);
        chk("upd2_pulse", {31'b0, reg_updated[2]}, 32'd1);
        step();
        chk("upd2_clear", {31'b0, reg_updated[2]}, 32'd0);
        req(1, 4'd2, 32'hAABB_CCDD, 4'b0101);
        step();
        chk("reg2_strb", rdreg(rd_data, 2), 32'h12BB_56DD);

        // Round-robin: three held requests to the same register
        req(0, 4'd5, 32'd1, 4'hF);
        req(1, 4'd5, 32'd2, 4'hF);
        req(2, 4'd5, 32'd3, 4'hF);
        step();
        chk("rr_reg5_a", rdreg(rd_data, 5), 32'd1);
        step();
        chk("rr_reg5_b", rdreg(rd_data, 5), 32'd2);
        step();
        chk("rr_reg5_c", rdreg(rd_data, 5), 32'd3);
        chk("rr_done", {29'b0, m_req}, 32'd0);

        // RO error alongside a contended register
        req(0, 4'd15, 32'hDEAD_BEEF, 4'hF);
        req(1, 4'd1, 32'h1111_1111, 4'hF);
        req(2, 4'd1, 32'h2222_2222, 4'hF);
        step();
        chk("ro_stall_m2", {29'b0, m_req}, 32'b100);
        step();
        chk("ro_reg15", rdreg(rd_data, 15), 32'h0);
        chk("ro_reg1", rdreg(rd_data, 1), 32'h2222_2222);

        // Reset while a request is pending
        req(1, 4'd4, 32'h0000_0099, 4'hF);
        m_rst = 1'b1;
        step(); step();
        chk("rst_reg4", rdreg(rd_data, 4), 32'h0);
        m_rst = 1'b0;
        step();
        chk("rst_retry_reg4", rdreg(rd_data, 4), 32'h0000_0099);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int m = 0; m < NM; m++)
                if (!m_req[m] && $urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 9);
                    req(m, (r < 7) ? 4'($urandom_range(0, 3)) :
                           (r < 8) ? 4'd15 : 4'($urandom_range(0, 15)),
                        $urandom, 4'($urandom_range(0, 15)));
                end
            m_rst = ($urandom_range(0, 99) == 0);
            step();
        end
        m_rst = 1'b0;
        m_req = '0;
        step(); step();

        for (int n = 0; n < 50 && !f_done; n++) @(posedge clk);
        if (!f_done) chk("fp_timeout", 32'd0, 32'd1);
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        if (sb.size() > 0) chk("sb_drain", sb.size(), 32'd0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
